// File: rtl/fp_pkg.sv
// Shared single-precision definitions for the fmul/fadd output stages.
// Holds field widths, class/flag bit indices and the queued result payload.
package fp_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned CLS_W  = 5;
  localparam int unsigned FLG_W  = 3;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // One-hot class bit positions
  localparam int unsigned CLS_ZERO = 0;
  localparam int unsigned CLS_DEN  = 1;
  localparam int unsigned CLS_NORM = 2;
  localparam int unsigned CLS_INF  = 3;
  localparam int unsigned CLS_NAN  = 4;

  // Exception flag bit positions
  localparam int unsigned FLG_UF = 0;
  localparam int unsigned FLG_OF = 1;
  localparam int unsigned FLG_NV = 2;

  // One buffered result: 32b word + 5b class + 3b flags = 40b
  typedef struct packed {
    logic [WORD_W-1:0] result;
    logic [CLS_W-1:0]  cls;
    logic [FLG_W-1:0]  flags;
  } fp_entry_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single-precision classifier.
// Ports:
//   word_i  in  32  {sign, exp[7:0], frac[22:0]}
//   cls_c   out 5   one-hot {nan, inf, normal, denormal, zero}
module fp_classify
  import fp_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  output logic [CLS_W-1:0]  cls_c
);

  logic [EXP_W-1:0]  exp_w;
  logic [FRAC_W-1:0] frac_w;
  logic              unused_sign;

  assign exp_w       = word_i[WORD_W-2 -: EXP_W];
  assign frac_w      = word_i[FRAC_W-1:0];
  // Sign does not affect the class
  assign unused_sign = word_i[WORD_W-1];

  // Exactly one class bit is set for every encoding
  always_comb begin
    cls_c = '0;
    if (exp_w == '0) begin
      if (frac_w == '0) cls_c[CLS_ZERO] = 1'b1;
      else              cls_c[CLS_DEN]  = 1'b1;
    end else if (exp_w == EXP_MAX) begin
      if (frac_w == '0) cls_c[CLS_INF]  = 1'b1;
      else              cls_c[CLS_NAN]  = 1'b1;
    end else begin
      cls_c[CLS_NORM] = 1'b1;
    end
  end

endmodule

// File: rtl/fmul_result_buffer.sv
// Output stage of the combinational fmul: classifies each product, queues
// {result, class, flags} in a DEPTH-entry FIFO behind valid/ready, and keeps
// sticky {invalid, overflow, underflow} status for software.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid/in_ready                producer handshake (in_ready = !full)
//   in_result, in_overflow, in_underflow   fmul product and its flags
//   out_valid/out_ready              consumer handshake (out_valid = !empty)
//   out_result, out_class, out_flags head entry contents
//   sticky_flags, flags_clear        accumulated status and its clear
//   count                            occupancy 0..DEPTH
module fmul_result_buffer
  import fp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_result,
  input  logic              in_overflow,
  input  logic              in_underflow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_result,
  output logic [CLS_W-1:0]  out_class,
  output logic [FLG_W-1:0]  out_flags,
  output logic [FLG_W-1:0]  sticky_flags,
  input  logic              flags_clear,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W = CNT_W - 1;

  fp_entry_t         mem_q [DEPTH];
  fp_entry_t         mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [FLG_W-1:0]  sticky_q, sticky_d;

  logic [CLS_W-1:0]  in_cls_c;
  fp_entry_t         in_entry_c;
  logic              push_c;
  logic              pop_c;

  fp_classify u_classify (
    .word_i (in_result),
    .cls_c  (in_cls_c)
  );

  // Assemble the entry written on push
  always_comb begin
    in_entry_c                = '0;
    in_entry_c.result         = in_result;
    in_entry_c.cls            = in_cls_c;
    in_entry_c.flags[FLG_NV]  = in_cls_c[CLS_NAN];
    in_entry_c.flags[FLG_OF]  = in_overflow;
    in_entry_c.flags[FLG_UF]  = in_underflow;
  end

  // Handshake status depends only on registered state
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push_c    = in_valid & in_ready;
  assign pop_c     = out_valid & out_ready;

  // Next-state for storage, pointers, occupancy and sticky status
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    sticky_d = sticky_q;

    if (push_c) begin
      mem_d[wr_ptr_q] = in_entry_c;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Clear takes effect before the same-cycle push's flags are merged
    if (flags_clear) sticky_d = '0;
    if (push_c)      sticky_d = sticky_d | in_entry_c.flags;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sticky_q <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

  // Head entry straight from storage; stable while stalled
  assign out_result   = mem_q[rd_ptr_q].result;
  assign out_class    = mem_q[rd_ptr_q].cls;
  assign out_flags    = mem_q[rd_ptr_q].flags;
  assign sticky_flags = sticky_q;
  assign count        = count_q;

endmodule

// File: tb/tb_fmul_result_buffer.sv
// Self-checking bench for fmul_result_buffer: directed scenarios plus a
// randomized phase, all checked against a queue-based reference model.
module tb_fmul_result_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_result = '0;
  logic        in_overflow = 1'b0;
  logic        in_underflow = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_class;
  logic [2:0]  out_flags;
  logic [2:0]  sticky_flags;
  logic        flags_clear = 1'b0;
  logic [CNT_W-1:0] count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of {result, class, flags} and sticky status
  logic [39:0] mq[$];
  logic [2:0]  m_sticky = '0;

  fmul_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_overflow  (in_overflow),
    .in_underflow (in_underflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_class    (out_class),
    .out_flags    (out_flags),
    .sticky_flags (sticky_flags),
    .flags_clear  (flags_clear),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // IEEE-754 class from the field rules; bit order {nan, inf, norm, den, zero}
  function automatic logic [4:0] ref_class(input logic [31:0] w);
    int unsigned e = int'(w[30:23]);
    int unsigned f = int'(w[22:0]);
    if (e == 0)        return (f == 0) ? 5'b00001 : 5'b00010;
    else if (e == 255) return (f == 0) ? 5'b01000 : 5'b10000;
    else               return 5'b00100;
  endfunction

  task automatic compare_all();
    check_eq("count",     40'(count),        40'(mq.size()));
    check_eq("in_ready",  40'(in_ready),     40'(mq.size() < DEPTH));
    check_eq("out_valid", 40'(out_valid),    40'(mq.size() > 0));
    check_eq("sticky",    40'(sticky_flags), 40'(m_sticky));
    if (mq.size() > 0)
      check_eq("head", {out_result, out_class, out_flags}, mq[0]);
  endtask

  // One clock: update the model from the driven inputs, then compare
  task automatic step();
    bit          do_push, do_pop;
    logic [4:0]  c;
    logic [2:0]  fl;
    do_push = in_valid && (mq.size() < DEPTH);
    do_pop  = out_ready && (mq.size() > 0);
    c  = ref_class(in_result);
    fl = {c[4], in_overflow, in_underflow};
    @(posedge clk);
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back({in_result, c, fl});
    if (flags_clear) m_sticky = '0;
    if (do_push) m_sticky = m_sticky | fl;
    #1;
    compare_all();
  endtask

  task automatic drive(input bit v, input logic [31:0] w, input bit of, input bit uf,
                       input bit rdy, input bit clr);
    in_valid = v; in_result = w; in_overflow = of; in_underflow = uf;
    out_ready = rdy; flags_clear = clr;
  endtask

  // Empty the FIFO within a bounded number of cycles
  task automatic drain();
    drive(0, 32'h0, 0, 0, 1, 0);
    for (int i = 0; i < 2 * int'(DEPTH) && mq.size() > 0; i++) step();
    check_eq("drain_empty", 40'(count), 40'(0));
    drive(0, 32'h0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 4))
      0: w[30:23] = 8'h00;
      1: w[30:23] = 8'hFF;
      2: w[22:0]  = '0;
      default: ;
    endcase
    if ($urandom_range(0, 5) == 0) w[22:0] = '0;
    return w;
  endfunction

  initial begin
    // Reset state
    #12;
    check_eq("rst_count",  40'(count),     40'(0));
    check_eq("rst_ovalid", 40'(out_valid), 40'(0));
    check_eq("rst_iready", 40'(in_ready),  40'(1));
    check_eq("rst_head",   {out_result, out_class, out_flags}, 40'(0));
    check_eq("rst_sticky", 40'(sticky_flags), 40'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: normal 1.0 appears next cycle
    drive(1, 32'h3F800000, 0, 0, 0, 0);
    step();
    check_eq("t1_class", 40'(out_class), 40'(5'b00100));
    check_eq("t1_count", 40'(count), 40'(1));
    check_eq("t1_sticky", 40'(sticky_flags), 40'(0));
    drain();

    // 2: +inf with overflow, then a lone clear
    drive(1, 32'h7F800000, 1, 0, 0, 0);
    step();
    check_eq("t2_class", 40'(out_class), 40'(5'b01000));
    check_eq("t2_flags", 40'(out_flags), 40'(3'b010));
    check_eq("t2_sticky", 40'(sticky_flags), 40'(3'b010));
    drive(0, 32'h0, 0, 0, 0, 1);
    step();
    check_eq("t2_clear", 40'(sticky_flags), 40'(0));
    drain();

    // 3: NaN then denormal back-to-back, drained in order
    drive(1, 32'h7FC00000, 0, 0, 0, 0);
    step();
    drive(1, 32'h00000001, 0, 1, 0, 0);
    step();
    drive(0, 32'h0, 0, 0, 1, 0);
    check_eq("t3_first", 40'(out_class), 40'(5'b10000));
    step();
    check_eq("t3_second", 40'(out_class), 40'(5'b00010));
    check_eq("t3_sticky", 40'(sticky_flags), 40'(3'b101));
    drain();

    // 4: fill, extra push ignored, one pop frees a slot, wrap order
    for (int i = 0; i < int'(DEPTH); i++) begin
      drive(1, 32'h40000000 + 32'(i), 0, 0, 0, 0);
      step();
    end
    check_eq("t4_full_cnt", 40'(count), 40'(DEPTH));
    check_eq("t4_full_rdy", 40'(in_ready), 40'(0));
    drive(1, 32'hDEADBEEF, 0, 0, 0, 0);
    step();
    check_eq("t4_ignored", 40'(count), 40'(DEPTH));
    drive(0, 32'h0, 0, 0, 1, 0);
    step();
    check_eq("t4_pop_rdy", 40'(in_ready), 40'(1));
    drive(1, 32'h41000000, 0, 0, 0, 0);
    step();
    drain();

    // 5: steady push & pop at count 2
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h3F000000 + 32'(i), 0, 0, 0, 0);
      step();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, rand_word(), 0, 0, 1, 0);
      step();
    end
    check_eq("t5_count", 40'(count), 40'(2));
    drive(1, 32'h3F800000, 1, 0, 1, 1);
    step();
    check_eq("t5_clr_push", 40'(sticky_flags), 40'(3'b010));
    drain();

    // 6: async reset with three queued entries
    for (int i = 0; i < 3; i++) begin
      drive(1, rand_word(), 1, 1, 0, 0);
      step();
    end
    drive(0, 32'h0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #0.5;
    mq.delete();
    m_sticky = '0;
    check_eq("t6_count", 40'(count), 40'(0));
    check_eq("t6_ovalid", 40'(out_valid), 40'(0));
    check_eq("t6_sticky", 40'(sticky_flags), 40'(0));
    #0.5 rst_n = 1'b1;
    drive(1, 32'h12345678, 0, 0, 0, 0);
    step();
    check_eq("t6_head", 40'(out_result), 40'(32'h12345678));
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0);
      step();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
